fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding and load-use hazard unit, sitting between ID and the EX operand muxes.
//  - Tracks in-flight destination tags in an internal slot pipeline (slot 0 = EX, slot 1 = MEM, ...).
//  - Registers per-source bypass selects for EX.
//  - Raises a stall on load-use hazards for NUM_SRC operands.
//  - Counts stall cycles.
// PARAMETERS
//  REG_NUM_W   5  width of a register number
//  NUM_SRC     2  source operands checked per ID instruction
//  NUM_STAGES  3  tracked slots after ID (EX, MEM, WB); must be >= 1
//  LOAD_LAT    1  lowest slot index at which a load result can be forwarded (0..NUM_STAGES-1)
//  CNT_W       32 stall counter width
//  SEL_W       derived, $clog2(NUM_STAGES+1)
// PORTS
//  clk          in   1                clock
//  rst          in   1                asynchronous reset, active-low
//  id_valid     in   1                ID holds a real instruction
//  id_src_num   in   NUM_SRC*REG_NUM_W  source register numbers; operand i at [i*REG_NUM_W +: REG_NUM_W]
//  id_src_used  in   NUM_SRC          operand i is read by the instruction
//  id_wr_num    in   REG_NUM_W        destination register number
//  id_wr_en     in   1                instruction writes id_wr_num
//  id_is_load   in   1                instruction is a load
//  flush        in   1                kill instruction in ID (branch redirect)
//  stall        out  1                hold PC and IF/ID; bubble into EX
//  fwd_sel_ex   out  NUM_SRC*SEL_W    registered bypass select per operand, valid in EX
//                                     0 = register file; k+1 = result of slot k
//  stall_cnt    out  CNT_W            saturating count of stall cycles
// BEHAVIOUR
//  Reset (rst low, asynchronous):
//   - all slots invalid; fwd_sel_ex = 0; stall_cnt = 0.
//   - stall = 0, because every slot is invalid.
//  Slot k state: valid, wr_num, wr_en, is_load.
//   - A slot is a producer iff valid & wr_en & wr_num != 0.
//  Match for operand i:
//   - The operand is used, id_src_num[i] != 0, and at least one producer slot has equal wr_num.
//   - The youngest match (lowest k) wins.
//  Select (combinational): sel_i = k+1 of the winning match, else 0.
//  Hazard for operand i: the winning slot is a load with k < LOAD_LAT.
//  stall output (combinational): id_valid & !flush & OR(hazard_i).
//  Each posedge, all slots update at once:
//   - Slots shift: slot k+1 <= slot k; slot NUM_STAGES-1 retires.
//   - Slot 0 <= ID tag only if id_valid & !stall & !flush; otherwise slot 0 becomes invalid (bubble).
//   - fwd_sel_ex <= {sel_i} under the same condition; otherwise fwd_sel_ex <= 0.
//   - stall_cnt increments when stall = 1; it saturates at all-ones and never wraps.
//  Slots shift during a stall, so the blocking load advances.
//  - Latency: a hazard resolves after LOAD_LAT-k cycles; with LOAD_LAT=1 a back-to-back load-use costs exactly 1 stall cycle.
//  - Non-load producers never stall; they are bypassed from any slot, including slot 0 (EX result).
//  - Register 0: never matched, never stalls.
//  - Operands with id_src_used=0: ignored.
//  - Flush and hazard in the same cycle: flush wins; stall = 0, bubble inserted, counter unchanged.
//  - Same register written by several slots: the youngest slot always wins.
//  - Last slot (WB) writing the same register ID reads: forwarded from that slot (sel = NUM_STAGES).
//    The register file's same-cycle write-read ordering therefore does not matter.
//  - Reset mid-stall: slots cleared; stall drops within the same cycle.
// TESTING
//  1 add r3 (not a load) issued, then sub reading r3 next cycle
//    -> stall=0; sub's fwd_sel_ex operand = 1 (slot 0).
//  2 lw r5, then add r6,r5,r5 back-to-back
//    -> exactly 1 stall cycle; then fwd_sel_ex = {2,2}; stall_cnt = 1.
//  3 writers of r7 in slots 0 and 2, ID reads r7 -> sel = 1 (youngest wins).
//    Write to r0 then read r0 -> sel = 0, no stall.
//  4 lw r4 in slot 0, ID reads r4, flush=1
//    -> stall=0, slot 0 bubble, fwd_sel_ex = 0, stall_cnt unchanged.
//  5 CNT_W=4, 20 consecutive hazard cycles -> stall_cnt saturates at 15.
//    Assert rst mid-stall -> stall=0 and fwd_sel_ex=0 immediately.
//  6 NUM_STAGES=4, LOAD_LAT=2: lw r9, then use
//    -> 2 stall cycles; then sel = 3.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// ID-side bundle for the forwarding/hazard unit.
// master = ID stage driver, slave = hazard unit.
interface fwd_hazard_unit_if #(
  parameter int REG_NUM_W  = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic                         id_valid;
  logic [NUM_SRC*REG_NUM_W-1:0] id_src_num;
  logic [NUM_SRC-1:0]           id_src_used;
  logic [REG_NUM_W-1:0]         id_wr_num;
  logic                         id_wr_en;
  logic                         id_is_load;
  logic                         flush;
  logic                         stall;
  logic [NUM_SRC*SEL_W-1:0]     fwd_sel_ex;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output id_valid,
    output id_src_num,
    output id_src_used,
    output id_wr_num,
    output id_wr_en,
    output id_is_load,
    output flush,
    input  stall,
    input  fwd_sel_ex,
    input  stall_cnt
  );

  modport slave (
    input  id_valid,
    input  id_src_num,
    input  id_src_used,
    input  id_wr_num,
    input  id_wr_en,
    input  id_is_load,
    input  flush,
    output stall,
    output fwd_sel_ex,
    output stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation
// from a shifting pipeline of in-flight dest tags.
module fwd_hazard_unit #(
  parameter int REG_NUM_W  = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_unit_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  typedef logic [REG_NUM_W-1:0] reg_t;
  typedef logic [SEL_W-1:0]     sel_t;

  typedef struct packed {
    logic vld;
    logic we;
    logic ld;
    reg_t num;
  } slot_t;

  slot_t [NUM_STAGES-1:0]  slot_q;
  slot_t [NUM_STAGES-1:0]  slot_d;
  sel_t  [NUM_SRC-1:0]     sel_q;
  sel_t  [NUM_SRC-1:0]     sel_d;
  logic  [CNT_W-1:0]       cnt_q;
  logic  [CNT_W-1:0]       cnt_d;

  reg_t  [NUM_SRC-1:0]     src_c;
  logic  [NUM_STAGES-1:0]  prod_c;
  sel_t  [NUM_SRC-1:0]     sel_c;
  logic  [NUM_SRC-1:0]     haz_c;
  logic                    stall_c;
  logic                    accept_c;

  assign src_c = bus.id_src_num;

  // A slot can feed a bypass only if it really writes a non-zero reg.
  always_comb begin
    prod_c = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      prod_c[k] = slot_q[k].vld & slot_q[k].we &
                  (slot_q[k].num != '0);
    end
  end

  // Per-operand match; scanning old to young lets the youngest win.
  always_comb begin
    sel_c = '0;
    haz_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (bus.id_src_used[i] && (src_c[i] != '0) &&
            prod_c[k] && (slot_q[k].num == src_c[i])) begin
          sel_c[i] = sel_t'(k + 1);
          haz_c[i] = slot_q[k].ld && (k < LOAD_LAT);
        end
      end
    end
  end

  // Flush overrides a hazard: the killed instruction never waits.
  always_comb begin
    stall_c  = bus.id_valid & ~bus.flush & (|haz_c);
    accept_c = bus.id_valid & ~bus.flush & ~stall_c;
  end

  // Slots always advance so a blocking load keeps moving.
  always_comb begin
    slot_d = '0;
    for (int k = NUM_STAGES - 1; k >= 1; k--) begin
      slot_d[k] = slot_q[k-1];
    end
    if (accept_c) begin
      slot_d[0].vld = 1'b1;
      slot_d[0].we  = bus.id_wr_en;
      slot_d[0].ld  = bus.id_is_load;
      slot_d[0].num = bus.id_wr_num;
    end
  end

  // EX bypass select and saturating stall counter.
  always_comb begin
    sel_d = accept_c ? sel_c : '0;
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State update; reset empties all slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.fwd_sel_ex = sel_q;
  assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit across
// three parameter sets.
module tb_fwd_hazard_unit;
  localparam int K_STALL = 0;
  localparam int K_SEL   = 1;
  localparam int K_CNT   = 2;

  logic clk;
  logic rst;
  logic rst1;

  fwd_hazard_unit_if #(.REG_NUM_W(5), .NUM_SRC(2),
    .NUM_STAGES(3), .CNT_W(32)) b0 ();
  fwd_hazard_unit_if #(.REG_NUM_W(5), .NUM_SRC(2),
    .NUM_STAGES(3), .CNT_W(4)) b1 ();
  fwd_hazard_unit_if #(.REG_NUM_W(5), .NUM_SRC(2),
    .NUM_STAGES(4), .CNT_W(32)) b2 ();

  fwd_hazard_unit #(.REG_NUM_W(5), .NUM_SRC(2),
    .NUM_STAGES(3), .LOAD_LAT(1), .CNT_W(32))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fwd_hazard_unit #(.REG_NUM_W(5), .NUM_SRC(2),
    .NUM_STAGES(3), .LOAD_LAT(1), .CNT_W(4))
    u1 (.clk(clk), .rst(rst1), .bus(b1.slave));
  fwd_hazard_unit #(.REG_NUM_W(5), .NUM_SRC(2),
    .NUM_STAGES(4), .LOAD_LAT(2), .CNT_W(32))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    int          cyc;
    int          inst;
    int          kind;
    logic [63:0] exp;
    string       nm;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [63:0] act;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_lost = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int inst,
                                         input int kind);
    logic [63:0] r;
    r = '0;
    case (inst)
      0: case (kind)
           K_STALL: r = 64'(b0.stall);
           K_SEL:   r = 64'(b0.fwd_sel_ex);
           default: r = 64'(b0.stall_cnt);
         endcase
      1: case (kind)
           K_STALL: r = 64'(b1.stall);
           K_SEL:   r = 64'(b1.fwd_sel_ex);
           default: r = 64'(b1.stall_cnt);
         endcase
      default: case (kind)
           K_STALL: r = 64'(b2.stall);
           K_SEL:   r = 64'(b2.fwd_sel_ex);
           default: r = 64'(b2.stall_cnt);
         endcase
    endcase
    return r;
  endfunction

  // Monitor: compare every expectation due by this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      act = actual(e.inst, e.kind);
      n_chk++;
      if (act !== e.exp)
        $display("FAIL %s (dut%0d cyc %0d): got %0d want %0d",
                 e.nm, e.inst, e.cyc, act, e.exp);
      else
        n_pass++;
    end
  end

  task automatic chk(input int inst, input int kind,
                     input logic [63:0] v, input string nm);
    exp_t x;
    x.cyc  = cyc;
    x.inst = inst;
    x.kind = kind;
    x.exp  = v;
    x.nm   = nm;
    sbq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic v,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] wr,
                       input logic we, input logic ld,
                       input logic fl);
    case (inst)
      0: begin
        b0.id_valid = v;   b0.id_src_num = {s1, s0};
        b0.id_src_used = used; b0.id_wr_num = wr;
        b0.id_wr_en = we;  b0.id_is_load = ld; b0.flush = fl;
      end
      1: begin
        b1.id_valid = v;   b1.id_src_num = {s1, s0};
        b1.id_src_used = used; b1.id_wr_num = wr;
        b1.id_wr_en = we;  b1.id_is_load = ld; b1.flush = fl;
      end
      default: begin
        b2.id_valid = v;   b2.id_src_num = {s1, s0};
        b2.id_src_used = used; b2.id_wr_num = wr;
        b2.id_wr_en = we;  b2.id_is_load = ld; b2.flush = fl;
      end
    endcase
  endtask

  task automatic idle(input int inst);
    drive(inst, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    rst  = 1'b0;
    rst1 = 1'b0;
    idle(0); idle(1); idle(2);
    step();
    for (int i = 0; i < 3; i++) begin
      chk(i, K_STALL, 0, "rst_stall");
      chk(i, K_SEL,   0, "rst_sel");
      chk(i, K_CNT,   0, "rst_cnt");
    end
    step();
    rst  = 1'b1;
    rst1 = 1'b1;
    step();

    // 1: ALU producer bypassed from slot 0
    drive(0, 1, 1, 2, 2'b11, 3, 1, 0, 0);
    chk(0, K_STALL, 0, "t1_add_stall");
    step();
    drive(0, 1, 3, 4, 2'b11, 8, 1, 0, 0);
    chk(0, K_STALL, 0, "t1_sub_stall");
    step();
    chk(0, K_SEL, 1, "t1_sel");

    // 2: back-to-back load-use
    drive(0, 1, 1, 0, 2'b01, 5, 1, 1, 0);
    chk(0, K_STALL, 0, "t2_lw_stall");
    step();
    drive(0, 1, 5, 5, 2'b11, 6, 1, 0, 0);
    chk(0, K_STALL, 1, "t2_lu_stall");
    chk(0, K_CNT,   0, "t2_cnt0");
    step();
    chk(0, K_STALL, 0, "t2_release");
    chk(0, K_SEL,   0, "t2_bubble_sel");
    chk(0, K_CNT,   1, "t2_cnt1");
    step();
    chk(0, K_SEL, 10, "t2_sel");
    chk(0, K_CNT, 1,  "t2_cnt");

    // 3: youngest writer wins; r0 never matches
    drive(0, 1, 0, 0, 2'b00, 7, 1, 1, 0);
    step();
    drive(0, 1, 0, 0, 2'b00, 10, 1, 0, 0);
    step();
    drive(0, 1, 0, 0, 2'b00, 7, 1, 0, 0);
    step();
    drive(0, 1, 7, 7, 2'b11, 11, 1, 0, 0);
    chk(0, K_STALL, 0, "t3_r7_stall");
    step();
    chk(0, K_SEL, 5, "t3_youngest");
    drive(0, 1, 0, 0, 2'b00, 0, 1, 1, 0);
    step();
    drive(0, 1, 0, 0, 2'b11, 0, 0, 0, 0);
    chk(0, K_STALL, 0, "t3_r0_stall");
    step();
    chk(0, K_SEL, 0, "t3_r0_sel");

    // 4: flush beats hazard and inserts a bubble
    drive(0, 1, 0, 0, 2'b00, 4, 1, 1, 0);
    step();
    drive(0, 1, 4, 0, 2'b01, 4, 1, 0, 1);
    chk(0, K_STALL, 0, "t4_flush_stall");
    step();
    chk(0, K_SEL, 0, "t4_sel");
    chk(0, K_CNT, 1, "t4_cnt");
    drive(0, 1, 4, 0, 2'b01, 0, 0, 0, 0);
    chk(0, K_STALL, 0, "t4_after_stall");
    step();
    chk(0, K_SEL, 2, "t4_bubble");

    // unused operands are ignored
    drive(0, 1, 0, 0, 2'b00, 12, 1, 1, 0);
    step();
    drive(0, 1, 12, 12, 2'b00, 13, 1, 0, 0);
    chk(0, K_STALL, 0, "t_unused_stall");
    step();
    chk(0, K_SEL, 0, "t_unused_sel");
    chk(0, K_CNT, 1, "t_cnt_final");
    idle(0);

    // 5: saturating counter and reset mid-stall
    drive(1, 1, 5, 0, 2'b01, 5, 1, 1, 0);
    for (int j = 0; j < 43; j++) begin
      chk(1, K_STALL, 64'(j % 2), "t5_stall");
      chk(1, K_CNT, 64'((j / 2) > 15 ? 15 : (j / 2)), "t5_cnt");
      step();
    end
    rst1 = 1'b0;
    chk(1, K_STALL, 0, "t5_rst_stall");
    chk(1, K_SEL,   0, "t5_rst_sel");
    chk(1, K_CNT,   0, "t5_rst_cnt");
    step();
    rst1 = 1'b1;
    idle(1);

    // 6: deeper load latency
    drive(2, 1, 0, 0, 2'b00, 9, 1, 1, 0);
    chk(2, K_STALL, 0, "t6_lw_stall");
    step();
    drive(2, 1, 9, 9, 2'b11, 10, 1, 0, 0);
    chk(2, K_STALL, 1, "t6_stall_a");
    step();
    chk(2, K_STALL, 1, "t6_stall_b");
    chk(2, K_SEL,   0, "t6_bubble_sel");
    step();
    chk(2, K_STALL, 0, "t6_release");
    chk(2, K_CNT,   2, "t6_cnt");
    step();
    chk(2, K_SEL, 27, "t6_sel");
    idle(2);

    step();
    step();
    if (sbq.size() != 0) begin
      n_lost = sbq.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0",
               n_lost);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk + n_lost);
    $finish;
  end
endmodule
